wb_stage: RTL
=============

# wb_stage

Writeback stage sitting on the consumer side of the MEM/WB pipeline latch. It selects the result to commit (next PC, memory read data or ALU result), drives the register-file write port, and holds a one-cycle forwarding copy of the last committed write for the decode stage. It also runs the processor halt sequence: it freezes the upstream pipeline and raises a sticky `halted` flag.

## Interface
Parameters:
- DATA_W, 16, datapath and register width
- REG_AW, 4, register index width
- CNT_W, 16, retire counter width

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- wreg_in  in  REG_AW  destination register from MEM/WB latch
- halt_in  in  1  HLT instruction present in WB
- MemtoReg_in  in  1  select memory data
- RegWrite_in  in  1  instruction writes a register
- PCS_in  in  1  select next PC (PCS instruction)
- npc_in  in  DATA_W  PC+2 of instruction
- mem_in  in  DATA_W  memory read data
- alu_in  in  DATA_W  ALU result
- rf_we  out  1  register-file write enable
- rf_wreg  out  REG_AW  register-file write index
- rf_wdata  out  DATA_W  register-file write data
- fwd_valid  out  1  forwarding entry valid (registered)
- fwd_reg  out  REG_AW  forwarding register index (registered)
- fwd_data  out  DATA_W  forwarding data (registered)
- pipe_en  out  1  enable to all upstream latches and the PC
- halted  out  1  processor halted, sticky until reset
- retire_cnt  out  CNT_W  committed-write count (only with WB_RETIRE_CNT_EN)

## Operation
- Data select, priority order: PCS_in → npc_in; else MemtoReg_in → mem_in; else alu_in. The result drives rf_wdata unconditionally.
- rf_wreg = wreg_in.
- rf_we = RegWrite_in & ~halt_in & (wreg_in != 0) & (state == RUN). Writes to R0 are always suppressed.
- Forwarding register, loaded every cycle: fwd_valid ← rf_we, fwd_reg ← wreg_in, fwd_data ← selected data. An entry is therefore valid for exactly one cycle after its commit unless a new commit replaces it.
- FSM with two states, RUN and HALTED:
  - RUN → HALTED when halt_in = 1.
  - HALTED has no exit; only reset leaves it.
- halted = (state == HALTED).
- pipe_en = (state == RUN) & ~halt_in. It is combinational, so upstream latches freeze in the same cycle HLT is seen in WB.
- In HALTED:
  - rf_we = 0.
  - fwd_valid loads 0, so it is 0 one cycle after entering HALTED.
  - Latch inputs are ignored.
- halt_in together with RegWrite_in=1: the halt wins and no write occurs.

## Timing
- Select path and rf_we are combinational, with zero latency from the latch outputs. The register-file write lands on the same edge that advances the latch.
- Forwarding outputs lag rf_we by exactly 1 cycle.
- halted rises on the first edge after halt_in=1. pipe_en falls in the same cycle halt_in rises and stays low.
- Reset values, applied asynchronously when rst=0:
  - state = RUN, halted = 0
  - fwd_valid = 0, fwd_reg = 0, fwd_data = 0
  - retire_cnt = 0
- Reset asserted while HALTED returns to RUN, with pipe_en = 1 immediately.
- Deassertion of rst is synchronised externally.

## Configuration
- WB_RETIRE_CNT_EN defined:
  - retire_cnt port exists.
  - The counter increments by 1 on every cycle with rf_we=1 and wraps modulo 2^CNT_W (0xFFFF → 0x0000).
  - The counter holds while HALTED.
- WB_RETIRE_CNT_EN undefined: no counter and no retire_cnt port; all other behaviour is unchanged.

## Structure
- The shared package wb_pkg holds:
  - the state enum (RUN, HALTED)
  - DATA_W / REG_AW defaults
  - the R0 index constant
- One sub-module, wb_retire_counter (width-parameterised wrapping counter with enable). It is instantiated only under WB_RETIRE_CNT_EN.

## Test plan
- ALU write: RegWrite=1, wreg=3, alu=0x1234, others 0 → rf_we=1, rf_wdata=0x1234. Next cycle fwd_valid=1, fwd_reg=3, fwd_data=0x1234.
- Select priority: PCS=1, MemtoReg=1, npc=0x0042, mem=0xBEEF → rf_wdata=0x0042. Then PCS=0 → 0xBEEF.
- R0 suppression: RegWrite=1, wreg=0, alu=0xFFFF → rf_we=0. Next cycle fwd_valid=0. retire_cnt is unchanged.
- Halt: halt_in=1 with RegWrite=1, wreg=5 → rf_we=0 and pipe_en=0 in the same cycle. halted=1 next cycle. Later RegWrite pulses produce no writes.
- Reset mid-halt: drive rst=0 while HALTED → halted=0, pipe_en=1, fwd_valid=0 asynchronously, and retire_cnt=0.
- Counter wrap (WB_RETIRE_CNT_EN): preload via 65535 writes → retire_cnt=0xFFFF. One more write → 0x0000.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
package wb_pkg;

  typedef enum logic [0:0] {
    StRun,
    StHalted
  } wb_state_e;

  localparam int unsigned DataW    = 16;
  localparam int unsigned RegAw    = 4;
  localparam int unsigned RegZero  = 0;

endpackage

// File: rtl/wb_retire_counter.sv
// Width-parameterised wrapping counter with enable; counts committed writes.
module wb_retire_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (en_i) count_d = count_q + Width'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: result select, register-file write port, one-cycle forwarding
// copy and halt sequencing. Define WB_RETIRE_CNT_EN to add the retire counter.
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = DataW,
  parameter int unsigned REG_AW = RegAw,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] wreg_in,
  input  logic              halt_in,
  input  logic              MemtoReg_in,
  input  logic              RegWrite_in,
  input  logic              PCS_in,
  input  logic [DATA_W-1:0] npc_in,
  input  logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] alu_in,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wreg,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic              pipe_en,
  output logic              halted
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]  retire_cnt
`endif
);

  wb_state_e         state_d, state_q;
  logic              fwd_valid_d, fwd_valid_q;
  logic [REG_AW-1:0] fwd_reg_d, fwd_reg_q;
  logic [DATA_W-1:0] fwd_data_d, fwd_data_q;
  logic [DATA_W-1:0] wdata;
  logic              run;

  assign run = (state_q == StRun);

  always_comb begin
    if (PCS_in)           wdata = npc_in;
    else if (MemtoReg_in) wdata = mem_in;
    else                  wdata = alu_in;
  end

  assign rf_wdata = wdata;
  assign rf_wreg  = wreg_in;
  assign rf_we    = RegWrite_in & ~halt_in & (wreg_in != REG_AW'(RegZero)) & run;
  // Combinational so upstream latches freeze in the very cycle HLT reaches WB.
  assign pipe_en  = run & ~halt_in;
  assign halted   = (state_q == StHalted);

  always_comb begin
    state_d     = state_q;
    fwd_valid_d = rf_we;
    fwd_reg_d   = wreg_in;
    fwd_data_d  = wdata;
    if (run && halt_in) state_d = StHalted;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StRun;
      fwd_valid_q <= 1'b0;
      fwd_reg_q   <= '0;
      fwd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_reg_q   <= fwd_reg_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  assign fwd_valid = fwd_valid_q;
  assign fwd_reg   = fwd_reg_q;
  assign fwd_data  = fwd_data_q;

`ifdef WB_RETIRE_CNT_EN
  // rf_we is already forced low while halted, so the count holds there.
  wb_retire_counter #(
    .Width(CNT_W)
  ) u_retire_counter (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (rf_we),
    .count_o(retire_cnt)
  );
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule
